// File: rtl/ast_mux_pkg.sv
// ast_mux_pkg: shared state encoding and default parameter constants for ast_mux.
package ast_mux_pkg;

    localparam int AST_MUX_DATA_W    = 64;
    localparam int AST_MUX_CHANNEL_W = 2;
    localparam int AST_MUX_IN_CNT    = 4;

    // Packet-level arbitration state: IDLE is also the one-cycle bubble between packets.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ast_mux_state_e;

endpackage : ast_mux_pkg

// File: rtl/ast_rr_arb.sv
// ast_rr_arb: combinational round-robin pick. Searches upward from last_grant+1
// with wrap-around; the first requesting input wins. When nothing requests,
// grant echoes last_grant and the caller must not register it.
module ast_rr_arb #(
    parameter  int IN_CNT = 4,
    localparam int IDX_W  = (IN_CNT > 1) ? $clog2(IN_CNT) : 1
) (
    input  logic [IN_CNT-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant
);

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        logic hit;
        int   idx;
        grant = last_grant;
        hit   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= IN_CNT; k++) begin
            idx = (int'(last_grant) + k) % IN_CNT;
            if (!hit && req[idx]) begin
                grant = IDX_W'(idx);
                hit   = 1'b1;
            end
        end
    end

endmodule : ast_rr_arb

// File: rtl/ast_mux.sv
// ast_mux: IN_CNT-to-1 Avalon-ST packet multiplexer. A grant is taken in IDLE,
// held for a whole packet in LOCKED, and released on the accepted eop beat.
// Config macro AST_MUX_OUT_REG_EN: when defined, the merged stream is driven
// from a 2-entry skid register (1-cycle latency, registered upstream ready);
// when undefined, the granted input is forwarded combinationally.
module ast_mux
    import ast_mux_pkg::*;
#(
    parameter int DATA_W    = AST_MUX_DATA_W,
    parameter int EMPTY_W   = $clog2(DATA_W/8),
    parameter int CHANNEL_W = AST_MUX_CHANNEL_W,
    parameter int IN_CNT    = AST_MUX_IN_CNT
) (
    input  logic                            clk_i,
    input  logic                            srst_n_i,
    input  logic [IN_CNT-1:0][DATA_W-1:0]   ast_data_i,
    input  logic [IN_CNT-1:0]               ast_startofpacket_i,
    input  logic [IN_CNT-1:0]               ast_endofpacket_i,
    input  logic [IN_CNT-1:0]               ast_valid_i,
    input  logic [IN_CNT-1:0][EMPTY_W-1:0]  ast_empty_i,
    output logic [IN_CNT-1:0]               ast_ready_o,
    output logic [DATA_W-1:0]               ast_data_o,
    output logic                            ast_startofpacket_o,
    output logic                            ast_endofpacket_o,
    output logic                            ast_valid_o,
    output logic [EMPTY_W-1:0]              ast_empty_o,
    output logic [CHANNEL_W-1:0]            ast_channel_o,
    input  logic                            ast_ready_i
);

    localparam int IDX_W = (IN_CNT > 1) ? $clog2(IN_CNT) : 1;

    if (CHANNEL_W < $clog2(IN_CNT)) begin : g_bad_channel_w
        $error("ast_mux: CHANNEL_W too narrow to encode IN_CNT inputs");
    end
    if (IN_CNT < 2) begin : g_bad_in_cnt
        $error("ast_mux: IN_CNT must be at least 2");
    end

    ast_mux_state_e   state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] arb_grant;

    logic              locked;
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic [DATA_W-1:0] sel_data;
    logic [EMPTY_W-1:0] sel_empty;
    logic              cap;      // downstream can take a beat this cycle
    logic              in_acc;   // granted input beat transfers this edge

    ast_rr_arb #(.IN_CNT(IN_CNT)) u_arb (
        .req        (ast_valid_i),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    assign locked    = (state == LOCKED);
    assign sel_valid = ast_valid_i[grant];
    assign sel_sop   = ast_startofpacket_i[grant];
    assign sel_eop   = ast_endofpacket_i[grant];
    assign sel_data  = ast_data_i[grant];
    assign sel_empty = ast_empty_i[grant];
    assign in_acc    = locked && sel_valid && cap;

    // Packet FSM: grab a grant when anyone is valid, drop it after the eop beat.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(IN_CNT - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|ast_valid_i) begin
                        grant <= arb_grant;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_acc && sel_eop) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AST_MUX_OUT_REG_EN

    localparam int BEAT_W = CHANNEL_W + 2 + EMPTY_W + DATA_W;

    logic [1:0][BEAT_W-1:0] skid_mem;
    logic [1:0]             cnt;
    logic [1:0]             cnt_nxt;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   rdy_q;
    logic                   push;
    logic                   pop;
    logic [BEAT_W-1:0]      in_beat;

    assign cap     = rdy_q;
    assign push    = in_acc;
    assign pop     = (cnt != 2'd0) && ast_ready_i;
    assign cnt_nxt = cnt + 2'(push) - 2'(pop);
    assign in_beat = {CHANNEL_W'(grant), sel_sop, sel_eop, sel_empty, sel_data};

    // Two-entry skid FIFO; ready is re-registered from next occupancy so a beat
    // in flight always has a free slot, sustaining one beat per cycle at depth 1.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            skid_mem <= '0;
            cnt      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                skid_mem[wr_ptr] <= in_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt < 2'd2);
        end
    end

    assign ast_valid_o = (cnt != 2'd0);
    assign {ast_channel_o, ast_startofpacket_o, ast_endofpacket_o,
            ast_empty_o, ast_data_o} = skid_mem[rd_ptr];

    // Only the granted input sees the registered ready.
    always_comb begin
        ast_ready_o = '0;
        if (locked) begin
            ast_ready_o[grant] = rdy_q;
        end
    end

`else

    assign cap = ast_ready_i;

    // Combinational forward of the granted input; quiet in IDLE and under reset.
    always_comb begin
        ast_valid_o         = 1'b0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_data_o          = '0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;
        if (srst_n_i && locked) begin
            ast_valid_o         = sel_valid;
            ast_startofpacket_o = sel_sop;
            ast_endofpacket_o   = sel_eop;
            ast_data_o          = sel_data;
            ast_empty_o         = sel_empty;
            ast_channel_o       = CHANNEL_W'(grant);
        end
    end

    // Only the granted input sees downstream ready.
    always_comb begin
        ast_ready_o = '0;
        if (srst_n_i && locked) begin
            ast_ready_o[grant] = ast_ready_i;
        end
    end

`endif

endmodule : ast_mux

// File: tb/tb_ast_mux.sv
// tb_ast_mux: self-checking bench for ast_mux in its default (combinational) build.
// Sources are per-input beat queues; a packet-level scheduler model predicts
// every output beat, ready vector and bubble cycle.
module tb_ast_mux;

    localparam int DATA_W    = 64;
    localparam int EMPTY_W   = 3;
    localparam int CHANNEL_W = 2;
    localparam int IN_CNT    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           srst_n_i = 1'b0;
    logic [IN_CNT-1:0][DATA_W-1:0]  ast_data_i = '0;
    logic [IN_CNT-1:0]              ast_startofpacket_i = '0;
    logic [IN_CNT-1:0]              ast_endofpacket_i = '0;
    logic [IN_CNT-1:0]              ast_valid_i = '0;
    logic [IN_CNT-1:0][EMPTY_W-1:0] ast_empty_i = '0;
    logic [IN_CNT-1:0]              ast_ready_o;
    logic [DATA_W-1:0]              ast_data_o;
    logic                           ast_startofpacket_o;
    logic                           ast_endofpacket_o;
    logic                           ast_valid_o;
    logic [EMPTY_W-1:0]             ast_empty_o;
    logic [CHANNEL_W-1:0]           ast_channel_o;
    logic                           ast_ready_i = 1'b0;

    ast_mux #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W), .IN_CNT(IN_CNT)
    ) dut (
        .clk_i(clk), .srst_n_i(srst_n_i),
        .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
        .ast_empty_i(ast_empty_i), .ast_ready_o(ast_ready_o),
        .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
        .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
        .ast_ready_i(ast_ready_i)
    );

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

    typedef struct {
        logic [CHANNEL_W-1:0] ch;
        logic [DATA_W-1:0]    data;
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
        int                   cyc;
    } obs_t;

    typedef struct {
        int port; int len; int emp; int rmode; bit late0;
        int exp_beats; int exp_ch; int exp_emp; int exp_first;
    } vec_t;

    beat_t src_q[IN_CNT][$];   // what each source still has to send
    beat_t ref_q[IN_CNT][$];   // everything each source was given, in order
    obs_t  out_q[$];           // accepted output beats
    int    n_cmp = 0, n_err = 0, cyc = 0;
    int    m_grant = -1, m_last = IN_CNT - 1;
    logic  s_valid_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < IN_CNT; i++) s += src_q[i].size();
        return s;
    endfunction

    function automatic logic rdy_for(input int mode, input int n);
        if (mode == 1) return (n % 2 == 0);
        if (mode == 2) return ($urandom_range(0, 9) < 7);
        return 1'b1;
    endfunction

    task automatic push_pkt(input int p, input int len, input int emp);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.data  = {$urandom(), $urandom()};
            x.sop   = (b == 0);
            x.eop   = (b == len - 1);
            x.empty = (b == len - 1) ? EMPTY_W'(emp) : EMPTY_W'($urandom_range(0, 7));
            src_q[p].push_back(x);
            ref_q[p].push_back(x);
        end
    endtask

    // One clock: drive sources, check outputs against the scheduler model, advance.
    task automatic tick(input logic rst_n, input logic rdy);
        logic [IN_CNT-1:0] exp_rdy, taken;
        logic acc_m;
        int g;
        @(negedge clk);
        srst_n_i    = rst_n;
        ast_ready_i = rdy;
        for (int i = 0; i < IN_CNT; i++) begin
            if (src_q[i].size() > 0) begin
                ast_valid_i[i] = 1'b1;
                ast_data_i[i] = src_q[i][0].data;
                ast_startofpacket_i[i] = src_q[i][0].sop;
                ast_endofpacket_i[i] = src_q[i][0].eop;
                ast_empty_i[i] = src_q[i][0].empty;
            end else begin
                ast_valid_i[i] = 1'b0;
                ast_data_i[i] = '0;
                ast_startofpacket_i[i] = 1'b0;
                ast_endofpacket_i[i] = 1'b0;
                ast_empty_i[i] = '0;
            end
        end
        #2;
        s_valid_o = ast_valid_o;
        exp_rdy = '0;
        acc_m = 1'b0;
        g = m_grant;
        if (!rst_n || g < 0) begin
            chk("valid_o_idle", ast_valid_o, 0);
            chk("ready_o_idle", ast_ready_o, 0);
            if (!rst_n) begin
                chk("rst_data", ast_data_o, 0);
                chk("rst_ctl", {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, 0);
            end
        end else begin
            exp_rdy[g] = rdy;
            chk("ready_o", ast_ready_o, exp_rdy);
            chk("valid_o", ast_valid_o, src_q[g].size() > 0);
            if (src_q[g].size() > 0) begin
                chk("data_o", ast_data_o, src_q[g][0].data);
                chk("sop_o", ast_startofpacket_o, src_q[g][0].sop);
                chk("eop_o", ast_endofpacket_o, src_q[g][0].eop);
                chk("empty_o", ast_empty_o, src_q[g][0].empty);
                chk("channel_o", ast_channel_o, g);
                acc_m = rdy;
            end
        end
        if (ast_valid_o && ast_ready_i && srst_n_i)
            out_q.push_back('{ast_channel_o, ast_data_o, ast_startofpacket_o,
                              ast_endofpacket_o, ast_empty_o, cyc});
        if (!rst_n) begin
            m_grant = -1;
            m_last  = IN_CNT - 1;
        end else if (g < 0) begin
            for (int k = 1; k <= IN_CNT; k++) begin
                int c;
                c = (m_last + k) % IN_CNT;
                if (m_grant < 0 && src_q[c].size() > 0) m_grant = c;
            end
        end else if (acc_m && src_q[g][0].eop) begin
            m_last  = g;
            m_grant = -1;
        end
        taken = ast_valid_i & ast_ready_o & {IN_CNT{srst_n_i}};
        @(posedge clk);
        for (int i = 0; i < IN_CNT; i++)
            if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        cyc++;
    endtask

    task automatic drain(input int mode, input int start, input int budget);
        int n = start;
        while ((pending() > 0 || m_grant >= 0) && n < start + budget) begin
            tick(1'b1, rdy_for(mode, n));
            n++;
        end
        chk("drain_left", pending(), 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < IN_CNT; i++) begin
            src_q[i].delete();
            ref_q[i].delete();
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        out_q.delete();
    endtask

    vec_t vt[5];

    initial begin
        int base, nb, k0, tot;
        int ord[6];
        vt[0] = '{2, 3, 0, 0, 1'b0, 3, 2, 0, 1};
        vt[1] = '{1, 4, 0, 1, 1'b1, 4, 1, 0, 2};
        vt[2] = '{3, 1, 5, 0, 1'b0, 1, 3, 5, 1};
        vt[3] = '{0, 2, 7, 0, 1'b0, 2, 0, 7, 1};
        vt[4] = '{3, 5, 1, 1, 1'b0, 5, 3, 1, 2};
        ord = '{0, 1, 3, 0, 1, 3};

        // Single-packet vectors: latency, channel, data integrity, eop empty.
        foreach (vt[v]) begin
            do_reset();
            base = cyc;
            push_pkt(vt[v].port, vt[v].len, vt[v].emp);
            if (vt[v].late0) begin
                tick(1'b1, rdy_for(vt[v].rmode, 0));
                push_pkt(0, 2, 0);
                drain(vt[v].rmode, 1, 200);
            end else begin
                drain(vt[v].rmode, 0, 200);
            end
            nb = 0;
            foreach (out_q[k]) begin
                if (out_q[k].ch == CHANNEL_W'(vt[v].exp_ch)) begin
                    if (nb == 0) chk("first_beat_cyc", out_q[k].cyc - base, vt[v].exp_first);
                    if (nb < ref_q[vt[v].port].size())
                        chk("vec_data", out_q[k].data, ref_q[vt[v].port][nb].data);
                    if (out_q[k].eop) chk("vec_eop_empty", out_q[k].empty, vt[v].exp_emp);
                    nb++;
                end
            end
            chk("vec_beats", nb, vt[v].exp_beats);
        end

        // Round-robin among continuously valid 0, 1, 3 with one-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 1, 0);
            push_pkt(1, 1, 0);
            push_pkt(3, 1, 0);
        end
        drain(0, 0, 100);
        chk("rr_count", out_q.size(), 6);
        for (int k = 0; k < 6 && k < out_q.size(); k++) begin
            chk("rr_order", out_q[k].ch, ord[k]);
            if (k > 0) chk("rr_gap", out_q[k].cyc - out_q[k-1].cyc, 2);
        end

        // Reset after beat 2 of a 5-beat packet on input 2.
        do_reset();
        push_pkt(2, 5, 0);
        k0 = 0;
        while (out_q.size() < 2 && k0 < 20) begin
            tick(1'b1, 1'b1);
            k0++;
        end
        chk("pre_rst_beats", out_q.size(), 2);
        push_pkt(0, 1, 3);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("post_rst_valid", s_valid_o, 0);
        k0 = out_q.size();
        drain(0, 0, 100);
        chk("post_rst_beats", out_q.size() - k0, 4);
        if (out_q.size() > k0 + 1) begin
            chk("post_rst_ch", out_q[k0].ch, 0);
            chk("rest_ch", out_q[k0+1].ch, 2);
            chk("rest_nosop", out_q[k0+1].sop, 0);
        end

        // Random traffic against the scheduler model, then per-source order check.
        do_reset();
        tot = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p, l;
                p = $urandom_range(0, IN_CNT - 1);
                l = $urandom_range(1, 5);
                push_pkt(p, l, $urandom_range(0, 7));
                tot += l;
            end
            tick(1'b1, rdy_for(2, c));
        end
        drain(2, 0, 3000);
        chk("rand_beats", out_q.size(), tot);
        foreach (out_q[k]) begin
            int ch;
            ch = int'(out_q[k].ch);
            if (ref_q[ch].size() > 0) begin
                chk("rand_order", out_q[k].data, ref_q[ch][0].data);
                void'(ref_q[ch].pop_front());
            end else begin
                chk("rand_extra", out_q[k].ch, IN_CNT);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ast_mux
